// File: rtl/uart_tx_frame_gen_if.sv
// Parallel-load handshake and serial line bundle for uart_tx_frame_gen.
// master = word producer (drives payload/valid), slave = the transmitter.
interface uart_tx_frame_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART transmit engine: start / LSB-first data / optional parity / stop, one bit per CLK.
// Define UART_TX_HOLD_REG_EN to add a one-word holding register in front of the shifter.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    uart_tx_frame_gen_if.slave  tx_if
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    tx_out_q, tx_out_d;
    logic                    busy_q, busy_d;

    logic                    start_go;
    logic [DATA_WIDTH-1:0]   start_data;
    logic                    start_pe;
    logic                    start_pt;
    logic                    in_gap;

`ifdef UART_TX_HOLD_REG_EN
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    hold_par_en_q, hold_par_en_d;
    logic                    hold_par_typ_q, hold_par_typ_d;
    logic                    hold_full_q, hold_full_d;
`endif

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.busy   = busy_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_out_d   = tx_out_q;
        start_go   = 1'b0;
        start_data = tx_if.P_DATA;
        start_pe   = tx_if.PAR_EN;
        start_pt   = tx_if.PAR_TYP;
        in_gap     = (state_q == IDLE) || (state_q == STOP);

`ifdef UART_TX_HOLD_REG_EN
        hold_data_d    = hold_data_q;
        hold_par_en_d  = hold_par_en_q;
        hold_par_typ_d = hold_par_typ_q;
        hold_full_d    = hold_full_q;
        // A full hold drains into the shifter at the frame boundary, freeing the slot for a new word on the same edge.
        if (in_gap && hold_full_q) begin
            start_go    = 1'b1;
            start_data  = hold_data_q;
            start_pe    = hold_par_en_q;
            start_pt    = hold_par_typ_q;
            hold_full_d = tx_if.Data_Valid;
        end else if (in_gap) begin
            start_go = tx_if.Data_Valid;
        end else if (!hold_full_q) begin
            hold_full_d = tx_if.Data_Valid;
        end
        if (tx_if.Data_Valid && !(in_gap && !hold_full_q) && !(!in_gap && hold_full_q)) begin
            hold_data_d    = tx_if.P_DATA;
            hold_par_en_d  = tx_if.PAR_EN;
            hold_par_typ_d = tx_if.PAR_TYP;
        end
`else
        start_go = in_gap && tx_if.Data_Valid && !busy_q;
`endif

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
            end
            START: begin
                state_d  = DATA;
                cnt_d    = '0;
                tx_out_d = shift_q[0];
                shift_d  = shift_q >> 1;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = par_bit_q;
                    end else begin
                        state_d  = STOP;
                        tx_out_d = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    tx_out_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            PARITY: begin
                state_d  = STOP;
                tx_out_d = 1'b1;
            end
            STOP: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
            end
        endcase

        if (start_go) begin
            state_d   = START;
            tx_out_d  = 1'b0;
            shift_d   = start_data;
            par_en_d  = start_pe;
            par_bit_d = start_pt ? ~^start_data : ^start_data;
        end

`ifdef UART_TX_HOLD_REG_EN
        busy_d = hold_full_d;
`else
        busy_d = (state_d == START) || (state_d == DATA) || (state_d == PARITY);
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_HOLD_REG_EN
            hold_data_q    <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_typ_q <= 1'b0;
            hold_full_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
`ifdef UART_TX_HOLD_REG_EN
            hold_data_q    <= hold_data_d;
            hold_par_en_q  <= hold_par_en_d;
            hold_par_typ_q <= hold_par_typ_d;
            hold_full_q    <= hold_full_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench for uart_tx_frame_gen: the driver pushes the expected line/busy
// sequence of each accepted word, a monitor pops one entry per cycle and compares.
module tb_uart_tx_frame_gen;
    localparam int W = 8;

    typedef struct packed {
        logic tx;
        logic busy;
    } line_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_frame_gen_if #(.DATA_WIDTH(W)) tx_if ();

    uart_tx_frame_gen #(.DATA_WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (tx_if.slave)
    );

    line_t exp_q[$];
    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    logic  cur_busy_model = 1'b0;
    logic  last_acc  = 1'b0;

    function automatic line_t mk(input logic t, input logic b);
        line_t l;
        l.tx   = t;
        l.busy = b;
        return l;
    endfunction

    // Reference frame: start 0, payload LSB first, optional parity making the 1-count even/odd, stop 1.
    function automatic void push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        int ones;
        logic par;
        ones = $countones(d);
        par  = pt ? logic'(1 - (ones % 2)) : logic'(ones % 2);
        exp_q.push_back(mk(1'b0, 1'b1));
        for (int i = 0; i < W; i++) exp_q.push_back(mk(d[i], 1'b1));
        if (pe) exp_q.push_back(mk(par, 1'b1));
        exp_q.push_back(mk(1'b1, 1'b0));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        line_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b1, 1'b0);
            cur_busy_model = e.busy;
            checks++;
            if (tx_if.TX_OUT !== e.tx || tx_if.busy !== e.busy) begin
                failures++;
                $display("FAIL line cyc=%0d tx=%b busy=%b expected tx=%b busy=%b",
                         cyc, tx_if.TX_OUT, tx_if.busy, e.tx, e.busy);
            end
        end
    end

    task automatic drive(input logic dv, input logic [W-1:0] d, input logic pe,
                         input logic pt, input logic rst_n);
        @(negedge CLK);
        RST              = rst_n;
        tx_if.Data_Valid = dv;
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pe;
        tx_if.PAR_TYP    = pt;
        last_acc         = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
        end else if (dv && !cur_busy_model) begin
            push_frame(d, pe, pt);
            last_acc = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    // Shift in n line samples (first sample ends up most significant) and count busy cycles.
    task automatic capture(input int n, output logic [15:0] bits, output int busy_cnt);
        bits     = '0;
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            bits = {bits[14:0], tx_if.TX_OUT};
            if (tx_if.busy === 1'b1) busy_cnt++;
        end
    endtask

    initial begin : stim
        logic [15:0] got;
        int          bcnt;
        int          waited;

        tx_if.Data_Valid = 1'b0;
        tx_if.P_DATA     = '0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        RST              = 1'b0;
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_tx", int'(tx_if.TX_OUT), 1);
        check("reset_busy", int'(tx_if.busy), 0);
        idle(3);

        drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        fork
            idle(12);
            capture(11, got, bcnt);
        join
        check("even_par_frame", int'(got), int'(16'b01010010101));
        check("even_par_busy", bcnt, 10);

        drive(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        fork
            idle(12);
            capture(11, got, bcnt);
        join
        check("odd_par_frame", int'(got), int'(16'b01010010111));

        drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
        fork
            idle(12);
            capture(10, got, bcnt);
        join
        check("nopar_frame", int'(got), int'(16'b0001111001));
        check("nopar_busy", bcnt, 9);

        drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        waited = 0;
        for (int i = 1; i <= 14; i++) begin
            drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
            if (last_acc) begin
                waited = i;
                break;
            end
        end
        check("b2b_accept_slot", waited, W + 2);
        idle(14);

        drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        idle(5);
        drive(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        @(posedge CLK);
        #2;
        check("midframe_reset_tx", int'(tx_if.TX_OUT), 1);
        check("midframe_reset_busy", int'(tx_if.busy), 0);
        idle(1);
        drive(1'b1, 8'h96, 1'b1, 1'b1, 1'b1);
        fork
            idle(12);
            capture(11, got, bcnt);
        join
        check("post_reset_frame", int'(got), int'(16'b00110100111));

        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 2) == 0), W'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 119) != 0));
        end
        idle(16);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
